// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch constants, state encoding and IF/ID bundle
package fetch_stage_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  // IF/ID bundle, also consumed by decode
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with hold/bubble/load controls
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   bubble_i,
  input  logic   load_i,
  input  if_id_t load_data_i,
  output if_id_t q_o
);

  if_id_t bubble_val;
  if_id_t ifid_q;

  assign bubble_val = '{pc: '0, instr: NOP, valid: 1'b0};

  // Reset and bubble both insert a NOP; load captures the fetched word; otherwise hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid_q <= bubble_val;
    end else if (bubble_i) begin
      ifid_q <= bubble_val;
    end else if (load_i) begin
      ifid_q <= load_data_i;
    end
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage: pc, redirect, stall, halt
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt_req,
  output logic [PC_W-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            fetch_misalign,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     count_q, count_d;
  logic            misalign_q;
  logic            halted_q;

  logic   in_run;
  logic   do_redirect;
  logic   do_halt;
  logic   do_advance;
  if_id_t load_data;
  if_id_t ifid;

  // Priority decode: redirect > halt_req > stall > advance, only while running
  always_comb begin
    in_run      = (state_q == FS_RUN);
    do_redirect = in_run & redirect;
    do_halt     = in_run & ~redirect & halt_req;
    do_advance  = in_run & ~redirect & ~halt_req & ~stall;

    pc_d = pc_q;
    if (do_redirect) begin
      pc_d = {redirect_target[PC_W-1:2], 2'b00};
    end else if (do_advance) begin
      pc_d = pc_q + 32'd4;
    end

    count_d = count_q;
    if (do_advance) begin
      count_d = count_q + 32'd1;
    end

    load_data = '{pc: pc_q, instr: imem_instr, valid: 1'b1};
  end

  // Fetch state machine with registered pc, counter and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_RUN;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        FS_RUN: begin
          pc_q       <= pc_d;
          count_q    <= count_d;
          misalign_q <= do_redirect & (|redirect_target[1:0]);
          if (do_halt) begin
            state_q  <= FS_HALT;
            halted_q <= 1'b1;
          end
        end
        FS_HALT: begin
          misalign_q <= 1'b0;
          halted_q   <= 1'b1;
        end
        default: begin
          state_q <= FS_RUN;
        end
      endcase
    end
  end

  // Bubble on redirect or halt entry; load only on a real advance so X on imem is ignored otherwise
  fetch_stage_if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i       (clk),
    .rst_i       (rst),
    .bubble_i    (do_redirect | do_halt),
    .load_i      (do_advance),
    .load_data_i (load_data),
    .q_o         (ifid)
  );

  assign imem_addr      = pc_q;
  assign if_id_pc       = ifid.pc;
  assign if_id_instr    = ifid.instr;
  assign if_id_valid    = ifid.valid;
  assign fetch_misalign = misalign_q;
  assign halted         = halted_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_misalign;
  logic        halted;
  logic [31:0] fetch_count;

  logic        xmem;
  int          n_vec;
  int          n_bad;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .fetch_misalign  (fetch_misalign),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, then an address-tagged pattern
  always_comb begin
    if (xmem) imem_instr = 32'hxxxx_xxxx;
    else if (imem_addr == 32'h0) imem_instr = 32'h0140_0313;
    else if (imem_addr == 32'h4) imem_instr = 32'h01E0_0393;
    else imem_instr = {16'hC0DE, imem_addr[15:0]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic v);
    chk({tag, ".pc"}, if_id_pc, pc);
    chk({tag, ".instr"}, if_id_instr, ins);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, 32'h0);
    chk_ifid(tag, 32'h0, 32'h0000_0013, 1'b0);
    chk({tag, ".misalign"}, {31'b0, fetch_misalign}, 32'h0);
    chk({tag, ".halted"}, {31'b0, halted}, 32'h0);
    chk({tag, ".count"}, fetch_count, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    xmem = 1'b0;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    halt_req = 1'b0;
    step();
    step();
    chk_reset("reset");

    // Free run from RESET_PC
    rst = 1'b0;
    chk("run0.addr", imem_addr, 32'h0);
    step();
    chk("run1.addr", imem_addr, 32'h4);
    chk_ifid("run1", 32'h0, 32'h0140_0313, 1'b1);
    chk("run1.count", fetch_count, 32'd1);
    step();
    chk("run2.addr", imem_addr, 32'h8);
    chk_ifid("run2", 32'h4, 32'h01E0_0393, 1'b1);
    chk("run2.count", fetch_count, 32'd2);

    // Two stall cycles with X on the memory bus
    stall = 1'b1;
    xmem = 1'b1;
    step();
    step();
    chk("stall.addr", imem_addr, 32'h8);
    chk_ifid("stall", 32'h4, 32'h01E0_0393, 1'b1);
    chk("stall.count", fetch_count, 32'd2);
    stall = 1'b0;
    xmem = 1'b0;
    step();
    chk("resume.addr", imem_addr, 32'hC);
    chk_ifid("resume", 32'h8, 32'hC0DE_0008, 1'b1);
    chk("resume.count", fetch_count, 32'd3);

    // Redirect beats a simultaneous stall
    redirect = 1'b1;
    redirect_target = 32'h20;
    stall = 1'b1;
    xmem = 1'b1;
    step();
    chk("redir.addr", imem_addr, 32'h20);
    chk_ifid("redir", 32'h0, 32'h0000_0013, 1'b0);
    chk("redir.misalign", {31'b0, fetch_misalign}, 32'h0);
    chk("redir.count", fetch_count, 32'd3);
    redirect = 1'b0;
    stall = 1'b0;
    xmem = 1'b0;
    step();
    chk_ifid("target", 32'h20, 32'hC0DE_0020, 1'b1);
    chk("target.addr", imem_addr, 32'h24);
    chk("target.count", fetch_count, 32'd4);

    // Misaligned target is word-aligned and flagged for one cycle
    redirect = 1'b1;
    redirect_target = 32'h22;
    step();
    chk("mis.addr", imem_addr, 32'h20);
    chk("mis.pulse", {31'b0, fetch_misalign}, 32'h1);
    redirect = 1'b0;
    step();
    chk("mis.clear", {31'b0, fetch_misalign}, 32'h0);
    chk_ifid("mis.next", 32'h20, 32'hC0DE_0020, 1'b1);
    chk("mis.count", fetch_count, 32'd5);

    // PC wraps modulo 2^32
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk("wrap.addr1", imem_addr, 32'h0);
    chk_ifid("wrap", 32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b1);
    chk("wrap.count", fetch_count, 32'd6);

    // Halt at pc 0x10, then redirect/stall are ignored
    redirect = 1'b1;
    redirect_target = 32'h10;
    step();
    redirect = 1'b0;
    halt_req = 1'b1;
    xmem = 1'b1;
    step();
    chk("halt.flag", {31'b0, halted}, 32'h1);
    chk("halt.addr", imem_addr, 32'h10);
    chk_ifid("halt", 32'h0, 32'h0000_0013, 1'b0);
    chk("halt.count", fetch_count, 32'd6);
    halt_req = 1'b0;
    redirect = 1'b1;
    redirect_target = 32'h43;
    step();
    step();
    chk("halted.addr", imem_addr, 32'h10);
    chk("halted.flag", {31'b0, halted}, 32'h1);
    chk("halted.misalign", {31'b0, fetch_misalign}, 32'h0);
    chk_ifid("halted", 32'h0, 32'h0000_0013, 1'b0);
    chk("halted.count", fetch_count, 32'd6);
    redirect = 1'b0;
    xmem = 1'b0;

    // Reset leaves HALT
    rst = 1'b1;
    step();
    chk_reset("rst_halt");
    rst = 1'b0;
    step();
    chk_ifid("rerun", 32'h0, 32'h0140_0313, 1'b1);
    chk("rerun.count", fetch_count, 32'd1);
    step();
    chk("rerun.addr", imem_addr, 32'h8);

    // Reset during stall with a pending redirect discards everything
    stall = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h80;
    rst = 1'b1;
    step();
    chk_reset("rst_stall");
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    step();
    chk_ifid("post_rst", 32'h0, 32'h0140_0313, 1'b1);
    chk("post_rst.addr", imem_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline.
- Owns the program counter and drives the combinational instruction-memory address. It captures the returned instruction into the IF/ID pipeline register.
- Handles load-use stalls from the hazard unit, branch/jump redirects from EX, and a sticky halt. Keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected on bubbles (addi x0,x0,0).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals pc, combinational.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- stall  input  1  hazard unit hold request: freeze pc and IF/ID.
- redirect  input  1  EX-stage taken branch/jump.
- redirect_target  input  32  new PC on redirect.
- halt_req  input  1  stop fetching (ecall/ebreak decode); sticky until rst.
- if_id_pc  output  32  PC of the instruction in IF/ID.
- if_id_instr  output  32  instruction in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_misalign  output  1  one-cycle pulse: redirect_target[1:0] was non-zero.
- halted  output  1  fetch is in the HALT state.
- fetch_count  output  32  number of instructions written into IF/ID with valid=1.

Behaviour:
- Reset values (rst high at an edge):
  - pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - fetch_misalign=0, halted=0, fetch_count=0, state=RUN.
- Reset mid-operation discards everything, including a pending redirect or stall.
- States: RUN, HALT. No other states.
- RUN transitions, priority highest first:
  1. redirect=1:
     - pc <= {redirect_target[31:2],2'b00}.
     - IF/ID <= bubble: instr=NOP_INSTR, valid=0, pc=0.
     - fetch_misalign <= |redirect_target[1:0].
     - Redirect wins over stall and halt_req in the same cycle.
  2. halt_req=1 (no redirect):
     - state <= HALT.
     - IF/ID <= bubble. pc held.
  3. stall=1: pc, IF/ID and fetch_count all hold.
  4. Otherwise:
     - pc <= pc+32'd4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0).
     - if_id_pc <= pc, if_id_instr <= imem_instr, if_id_valid <= 1.
     - fetch_count <= fetch_count+1, wrapping.
- HALT state:
  - Only exit is rst. pc holds.
  - IF/ID holds the bubble.
  - redirect, stall and halt_req are ignored. fetch_misalign=0.
  - halted=1 (registered, asserted the cycle after the transition).
- fetch_misalign is registered and is high only in the cycle following the redirect edge.
- Latency:
  - imem_addr=pc in the same cycle.
  - An instruction appears in IF/ID one edge after its pc is presented.
  - Redirect costs exactly one bubble in IF/ID. The target instruction reaches IF/ID on the second edge after redirect.
- First edge after rst deasserts: IF/ID takes the instruction at RESET_PC.
- imem_instr is sampled only in the normal-advance case. X on imem_instr during stall, redirect or halt must not propagate.

Decomposition:
- Shared package holds:
  - NOP_INSTR constant.
  - PC width constant (32).
  - Fetch state encoding (RUN=1'b0, HALT=1'b1).
  - The IF/ID bundle fields (pc, instr, valid), also used by decode.
- Natural sub-module: if_id_reg, the IF/ID pipeline register with hold/bubble/load controls.
- PC next-value logic and the state machine stay in fetch_stage.

Test Plan:
- Reset then free-run, memory word0=0x01400313, word1=0x01E00393 -> imem_addr 0,4,8 on successive cycles; IF/ID = (pc 0, 0x01400313, valid 1), then (pc 4, 0x01E00393, valid 1); fetch_count=2 after two edges.
- Stall held 2 cycles at pc=8 -> imem_addr stays 8; IF/ID keeps (pc 4, 0x01E00393); fetch_count unchanged; advance resumes at pc 8.
- Redirect with target 0x20, stall also high -> next cycle pc=0x20, IF/ID valid=0 instr=0x00000013; following cycle IF/ID pc=0x20, valid=1.
- Redirect target 0x22 -> pc=0x20; fetch_misalign high exactly one cycle.
- halt_req at pc=0x10 -> halted=1 next cycle, pc frozen at 0x10, IF/ID bubble; later redirect ignored; rst returns pc=0, halted=0.
- pc forced near wrap via redirect 0xFFFF_FFFC then advance -> pc=0, IF/ID pc=0xFFFF_FFFC; rst asserted during a stall clears all state to the reset values.
